// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//   Elastic pipeline stage register for the RV32 core's inter-stage
//   boundaries. Data payload is held across bubbles; control payload is
//   zeroed whenever the stage holds no valid beat, so a bubble or a flushed
//   slot can never carry a live regWrite/memWrite downstream.
//   valid/ready handshake, synchronous flush (priority over load/hold),
//   saturating stall and bubble performance counters.
//
//   Build option: define PIPE_SKID_BUF_EN to add a 1-entry skid buffer and
//   make in_ready a registered signal (no in_ready <- out_ready comb path).
//   Without it, in_ready = out_ready | ~out_valid.
//
// Ports
//   clk         in   1       clock, rising edge
//   reset_n     in   1       asynchronous active-low reset
//   flush_i     in   1       synchronous squash of stage contents
//   in_valid    in   1       upstream beat valid
//   in_ready    out  1       stage can accept a beat this cycle
//   in_data     in   DATA_W  upstream data payload
//   in_ctrl     in   CTRL_W  upstream control payload
//   out_valid   out  1       stage holds a valid beat
//   out_ready   in   1       downstream accepts beat this cycle
//   out_data    out  DATA_W  registered data payload
//   out_ctrl    out  CTRL_W  registered control payload, 0 when !out_valid
//   stall_cnt   out  CNT_W   saturating count of out_valid & ~out_ready
//   bubble_cnt  out  CNT_W   saturating count of ~out_valid
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush_i,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
    logic [CNT_W-1:0]  stall_q, bubble_q;
    logic              load;
    logic              accept;

`ifdef PIPE_SKID_BUF_EN
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;

    // Ready straight from the skid-occupancy flop: no path from out_ready.
    assign in_ready = ~skid_valid_q;
`else
    assign in_ready = out_ready | ~valid_q;
`endif

    // Output slot may take a new value: empty or retiring this edge.
    assign load   = ~valid_q | out_ready;
    assign accept = in_valid & in_ready;

    // Next-state for output slot (and skid): flush > load > hold.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
`ifdef PIPE_SKID_BUF_EN
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_ctrl_d  = skid_ctrl_q;
`endif
        if (flush_i) begin
            // Data is left as-is; only valid/control matter for a squashed slot.
            valid_d = 1'b0;
            ctrl_d  = '0;
`ifdef PIPE_SKID_BUF_EN
            skid_valid_d = 1'b0;
`endif
        end else if (load) begin
`ifdef PIPE_SKID_BUF_EN
            if (skid_valid_q) begin
                // Older skid beat goes first; in_ready was low so nothing new arrives.
                valid_d      = 1'b1;
                data_d       = skid_data_q;
                ctrl_d       = skid_ctrl_q;
                skid_valid_d = 1'b0;
            end else
`endif
            begin
                valid_d = accept;
                if (accept) begin
                    data_d = in_data;
                    ctrl_d = in_ctrl;
                end else begin
                    ctrl_d = '0;
                end
            end
        end
`ifdef PIPE_SKID_BUF_EN
        else if (accept) begin
            // Output is stalled: park the incoming beat in the skid entry.
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
            skid_ctrl_d  = in_ctrl;
        end
`endif
    end

    // Stage storage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= '0;
`ifdef PIPE_SKID_BUF_EN
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_ctrl_q  <= '0;
`endif
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
`ifdef PIPE_SKID_BUF_EN
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_ctrl_q  <= skid_ctrl_d;
`endif
        end
    end

    // Saturating performance counters; sampled on pre-edge state, flush-agnostic.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (valid_q && !out_ready && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (!valid_q && (bubble_q != '1)) begin
                bubble_q <= bubble_q + CNT_W'(1);
            end
        end
    end

    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign out_ctrl   = ctrl_q;
    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;

endmodule
